// File: rtl/ir_beacon_tx.sv
// IR beacon carrier generator: continuous or mark/space bursts at FREQ_LO_HZ/FREQ_HI_HZ.
// Latency: ir_out rises 1 clk after enable is seen in IDLE; ir_out is registered.
// No backpressure: free-running once enabled; cycles and spaces always complete.
// Optional: define IR_TX_DUTY_EN to add duty_sel for a reduced carrier high time.
module ir_beacon_tx #(
  parameter int CLK_HZ       = 100000000,
  parameter int FREQ_LO_HZ   = 1000,
  parameter int FREQ_HI_HZ   = 10000,
  parameter int BURST_CYCLES = 8,
  parameter int GAP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic       freq_sel,
  input  logic       burst_en,
`ifdef IR_TX_DUTY_EN
  input  logic [1:0] duty_sel,
`endif
  output logic       ir_out,
  output logic       active,
  output logic       cycle_done,
  output logic       burst_done
);

  localparam int HALF_LO = CLK_HZ / (2 * FREQ_LO_HZ);
  localparam int HALF_HI = CLK_HZ / (2 * FREQ_HI_HZ);
  // Phase counter spans one full carrier period of the slow band.
  localparam int PW = $clog2(2 * HALF_LO + 1);
  localparam int CNT_MAX = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
  localparam int BW = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PER_LO = PW'(2 * HALF_LO);
  localparam logic [PW-1:0] PER_HI = PW'(2 * HALF_HI);
  localparam logic [BW-1:0] MARK_LAST = BW'(BURST_CYCLES - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;

  logic [1:0]    state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [PW-1:0] last_ph;   // period-1 of the carrier currently in use
  logic [PW-1:0] hi_time;   // clocks of ir_out high per carrier period
  logic [PW-1:0] sel_per;   // period implied by the live freq_sel
  logic [PW-1:0] sel_hi;    // high time implied by the live selects
  logic [PW-1:0] hi_n;
  logic          load;      // capture selects into last_ph/hi_time
  logic          cycle_end;

  assign sel_per   = freq_sel ? PER_HI : PER_LO;
  assign cycle_end = (phase == last_ph);

`ifdef IR_TX_DUTY_EN
  logic [1:0]    duty_eff;
  logic [PW-1:0] duty_hi;

  // Shortened high time; duty_sel=3 folds onto 2 and the result never drops below 1 clk.
  always_comb begin
    duty_eff = (duty_sel == 2'd3) ? 2'd2 : duty_sel;
    duty_hi  = sel_per >> (duty_eff + 2'd1);
    sel_hi   = (duty_hi == '0) ? PW'(1) : duty_hi;
  end
`else
  assign sel_hi = sel_per >> 1;
`endif

  // Next-state: decisions are taken only on the last clock of a carrier period.
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    load    = 1'b0;
    if (state == ST_IDLE) begin
      if (enable) begin
        state_n = ST_MARK;
        phase_n = '0;
        cnt_n   = '0;
        load    = 1'b1;
      end
    end else if (!cycle_end) begin
      phase_n = phase + 1'b1;
    end else begin
      phase_n = '0;
      if (state == ST_MARK) begin
        if (!enable) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (burst_en && (cnt == MARK_LAST)) begin
          state_n = ST_SPACE;
          cnt_n   = '0;
        end else begin
          cnt_n = burst_en ? cnt + 1'b1 : '0;
          load  = 1'b1;
        end
      end else begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (enable) begin
            state_n = ST_MARK;
            load    = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end

  assign hi_n = load ? sel_hi : hi_time;

  // State, counters and the registered LED drive; ir_out only moves at half boundaries.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      phase   <= '0;
      cnt     <= '0;
      last_ph <= '0;
      hi_time <= '0;
      ir_out  <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      ir_out <= (state_n == ST_MARK) && (phase_n < hi_n);
      if (load) begin
        last_ph <= sel_per - 1'b1;
        hi_time <= sel_hi;
      end
    end
  end

  assign active     = (state != ST_IDLE);
  assign cycle_done = active && cycle_end;
  assign burst_done = (state == ST_SPACE) && cycle_end && (cnt == GAP_LAST);

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Bench for ir_beacon_tx: CLK_HZ=20000 gives HALF_LO=10, HALF_HI=1; bursts of 2 mark / 3 gap.
// Stimulus queues the expected shape of every carrier period; a monitor measures each
// period (high clocks, low clocks, burst_done) at cycle_done and compares.
module tb_ir_beacon_tx;

  typedef struct {
    int hi;
    int lo;
    bit bd;
  } exp_t;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic enable = 1'b0;
  logic freq_sel = 1'b0;
  logic burst_en = 1'b0;
`ifdef IR_TX_DUTY_EN
  logic [1:0] duty_sel = 2'd0;
`endif
  logic ir_out, active, cycle_done, burst_done;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   hi_cnt = 0;
  int   lo_cnt = 0;

  ir_beacon_tx #(
    .CLK_HZ(20000), .FREQ_LO_HZ(1000), .FREQ_HI_HZ(10000),
    .BURST_CYCLES(2), .GAP_CYCLES(3)
  ) dut (
    .clk(clk), .Reset(Reset), .enable(enable), .freq_sel(freq_sel), .burst_en(burst_en),
`ifdef IR_TX_DUTY_EN
    .duty_sel(duty_sel),
`endif
    .ir_out(ir_out), .active(active), .cycle_done(cycle_done), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int hi, input int lo, input bit bd);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.bd = bd;
    exp_q.push_back(e);
  endtask

  // Returns on the posedge right after the last queued period was checked.
  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d periods still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ir_out"}, int'(ir_out), 0);
    chk({name, "_active"}, int'(active), 0);
  endtask

  // Monitor: measure each carrier period and compare it at cycle_done.
  always @(negedge clk) begin
    exp_t e;
    if (!active) begin
      hi_cnt = 0;
      lo_cnt = 0;
    end else begin
      if (ir_out) hi_cnt++;
      else lo_cnt++;
      if (cycle_done) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL period_unexpected: got hi=%0d lo=%0d bd=%0d, expected no period", hi_cnt, lo_cnt, burst_done);
        end else begin
          e = exp_q.pop_front();
          if (e.hi != hi_cnt || e.lo != lo_cnt || e.bd != burst_done) begin
            n_fail++;
            $display("FAIL period_shape: got hi=%0d lo=%0d bd=%0d, expected hi=%0d lo=%0d bd=%0d at %0t",
                     hi_cnt, lo_cnt, burst_done, e.hi, e.lo, e.bd, $time);
          end
        end
        hi_cnt = 0;
        lo_cnt = 0;
      end
    end
    if (burst_done) begin
      n_chk++;
      if (!cycle_done) begin
        n_fail++;
        $display("FAIL burst_done_align: got cycle_done=0, expected 1 at %0t", $time);
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ir_out", int'(ir_out), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_cycle_done", int'(cycle_done), 0);
    chk("rst_burst_done", int'(burst_done), 0);

    // Continuous low band straight out of reset.
    enable = 1'b1;
    repeat (3) push(10, 10, 0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("latency_ir_out", int'(ir_out), 1);
    chk("latency_active", int'(active), 1);
    wait_done("cont_lo");

    // Reset asserted mid-high-half acts without a clock.
    repeat (3) @(negedge clk);
    chk("pre_rst_ir_out", int'(ir_out), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_ir_out", int'(ir_out), 0);
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_cycle_done", int'(cycle_done), 0);
    chk("async_rst_burst_done", int'(burst_done), 0);
    repeat (2) push(10, 10, 0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ir_out", int'(ir_out), 1);
    wait_done("post_rst");

    // Frequency switch three clocks into a slow period: that period stays 20 clks.
    push(10, 10, 0);
    repeat (3) @(negedge clk);
    freq_sel = 1'b1;
    repeat (4) push(1, 1, 0);
    wait_done("freq_switch");

    // Back to slow band, then drop enable mid-MARK.
    push(1, 1, 0);
    @(negedge clk);
    freq_sel = 1'b0;
    push(10, 10, 0);
    wait_done("back_lo");
    push(10, 10, 0);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_done("en_drop_mark");
    @(negedge clk);
    chk_idle("idle_after_mark");
    chk("idle_cycle_done", int'(cycle_done), 0);

    // Burst mode: 2 marks of 20 clks, 3 spaces of 20 clks, burst_done on the last.
    burst_en = 1'b1;
    enable   = 1'b1;
    repeat (2) begin
      repeat (2) push(10, 10, 0);
      push(0, 20, 0);
      push(0, 20, 0);
      push(0, 20, 1);
    end
    wait_done("burst");

    // Enable dropped mid-SPACE: the gap completes with burst_done, then IDLE.
    repeat (2) push(10, 10, 0);
    push(0, 20, 0);
    push(0, 20, 0);
    push(0, 20, 1);
    repeat (50) @(negedge clk);
    chk("space_active", int'(active), 1);
    chk("space_ir_out", int'(ir_out), 0);
    enable = 1'b0;
    wait_done("en_drop_space");
    @(negedge clk);
    chk_idle("idle_after_space");

    // burst_en dropped mid-SPACE: the gap completes, then continuous carrier.
    enable = 1'b1;
    repeat (2) push(10, 10, 0);
    push(0, 20, 0);
    push(0, 20, 0);
    push(0, 20, 1);
    push(10, 10, 0);
    repeat (50) @(negedge clk);
    burst_en = 1'b0;
    repeat (60) @(negedge clk);
    chk("cont_after_space_active", int'(active), 1);
    enable = 1'b0;
    wait_done("burst_en_drop");
    @(negedge clk);
    chk_idle("idle_after_cont");

`ifdef IR_TX_DUTY_EN
    // Reduced duty: 5 high / 15 low, then minimum-1 rule at the fast band.
    duty_sel = 2'd1;
    enable   = 1'b1;
    repeat (2) push(5, 15, 0);
    wait_done("duty_lo");
    push(5, 15, 0);
    @(negedge clk);
    duty_sel = 2'd3;
    freq_sel = 1'b1;
    repeat (3) push(1, 1, 0);
    wait_done("duty_hi");
    push(1, 1, 0);
    @(negedge clk);
    enable = 1'b0;
    wait_done("duty_stop");
    @(negedge clk);
    chk_idle("idle_after_duty");
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
